// File: rtl/fsm_sw_sequencer.sv
// fsm_sw_sequencer
// Drives the 3-bit sw input of the LED state machine from one of two sources.
// MANUAL passes the synchronised board switches, AUTO plays a fixed pattern
// table advanced by a prescaled tick, and PAUSE freezes the pattern position.
// Two raw buttons select the source.
// Optional feature: define SEQ_DEBOUNCE_EN to debounce the manual switches
// (DEB_CYC stable cycles). If it is undefined, the synchronised switches are
// used directly.
`timescale 1ns/1ps
module fsm_sw_sequencer #(
  parameter int TICK_DIV = 100_000_000,
  parameter int DEB_CYC  = 1_000_000,
  parameter int SEQ_LEN  = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] sw_in,
  input  logic       btn_mode,
  input  logic       btn_hold,
  output logic [2:0] sw_out,
  output logic [1:0] mode,
  output logic [3:0] step_idx,
  output logic       seq_done
);

  localparam int              TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [3:0]      STEP_LAST = 4'(SEQ_LEN - 1);

  typedef enum logic [1:0] {
    ST_MANUAL = 2'b00,
    ST_AUTO   = 2'b01,
    ST_PAUSE  = 2'b10
  } state_e;

  // Reject parameter values that the counters cannot represent.
  if (TICK_DIV < 2 || DEB_CYC < 1 || SEQ_LEN < 1 || SEQ_LEN > 16) begin : g_param_check
    $error("fsm_sw_sequencer: parameter out of range");
  end

  // NOTE: the pattern table is a constant function that synthesises to logic.
  // It holds no state, so it needs no reset.
  function automatic logic [2:0] rom_lookup(input logic [3:0] idx);
    case (idx)
      4'd0:    rom_lookup = 3'b000;
      4'd1:    rom_lookup = 3'b001;
      4'd2:    rom_lookup = 3'b010;
      4'd3:    rom_lookup = 3'b011;
      4'd4:    rom_lookup = 3'b100;
      4'd5:    rom_lookup = 3'b101;
      4'd6:    rom_lookup = 3'b110;
      4'd7:    rom_lookup = 3'b001;
      4'd8:    rom_lookup = 3'b100;
      4'd9:    rom_lookup = 3'b101;
      4'd10:   rom_lookup = 3'b110;
      4'd11:   rom_lookup = 3'b111;
      default: rom_lookup = 3'b000;
    endcase
  endfunction

  logic [2:0] sw_s1_q, sw_s2_q;
  logic [1:0] btn_s1_q, btn_s2_q, btn_prev_q;  // [1] = mode button, [0] = hold button
  logic       mode_edge, hold_edge;

  // Two-flop synchronisers for all raw inputs, plus the previous button level.
  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // sample pre-edge values, and the synchroniser chain behaves as a real shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      btn_prev_q <= '0;
    end else begin
      sw_s1_q    <= sw_in;
      sw_s2_q    <= sw_s1_q;
      btn_s1_q   <= {btn_mode, btn_hold};
      btn_s2_q   <= btn_s1_q;
      btn_prev_q <= btn_s2_q;
    end
  end

  assign mode_edge = btn_s2_q[1] & ~btn_prev_q[1];
  assign hold_edge = btn_s2_q[0] & ~btn_prev_q[0];

  logic [2:0] filt_d;

`ifdef SEQ_DEBOUNCE_EN
  localparam int            DW       = $clog2(DEB_CYC + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);

  logic [2:0]    filt_q, cand_q, cand_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;

  // Debounce: accept a new switch value after DEB_CYC consecutive identical samples.
  // deb_cnt counts the samples already seen that equal the candidate value.
  // NOTE: every combinational output gets a default first. No path leaves a
  // value unassigned, so no latch is inferred.
  always_comb begin
    filt_d    = filt_q;
    cand_d    = cand_q;
    deb_cnt_d = deb_cnt_q;
    if (sw_s2_q == filt_q) begin
      deb_cnt_d = '0;
    end else if (sw_s2_q != cand_q) begin
      cand_d = sw_s2_q;
      if (DEB_CYC == 1) begin
        filt_d    = sw_s2_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = DW'(1);
      end
    end else if (deb_cnt_q >= DEB_LAST) begin
      filt_d    = sw_s2_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q    <= '0;
      cand_q    <= '0;
      deb_cnt_q <= '0;
    end else begin
      filt_q    <= filt_d;
      cand_q    <= cand_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end
`else
  assign filt_d = sw_s2_q;
`endif

  state_e        state_q, state_d;
  logic [3:0]    step_q, step_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    sw_out_q, sw_out_d;
  logic          seq_done_q, seq_done_d;

  // Mode FSM, tick prescaler and pattern stepping. If both buttons rise
  // together, the mode button wins.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    tick_d     = tick_q;
    sw_out_d   = sw_out_q;
    seq_done_d = 1'b0;
    case (state_q)
      ST_MANUAL: begin
        sw_out_d = filt_d;
        if (mode_edge) begin
          state_d = ST_AUTO;
          step_d  = '0;
          tick_d  = '0;
        end
      end
      ST_AUTO: begin
        sw_out_d = rom_lookup(step_q);
        if (mode_edge) begin
          state_d = ST_MANUAL;
          step_d  = '0;
          tick_d  = '0;
        end else if (hold_edge) begin
          state_d = ST_PAUSE;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (step_q == STEP_LAST) begin
            step_d     = '0;
            seq_done_d = 1'b1;
          end else begin
            step_d = step_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_PAUSE: begin
        if (mode_edge) begin
          state_d = ST_MANUAL;
          step_d  = '0;
          tick_d  = '0;
        end else if (hold_edge) begin
          state_d = ST_AUTO;
        end
      end
      default: begin
        state_d = ST_MANUAL;
        step_d  = '0;
        tick_d  = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_MANUAL;
      step_q     <= '0;
      tick_q     <= '0;
      sw_out_q   <= '0;
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      tick_q     <= tick_d;
      sw_out_q   <= sw_out_d;
      seq_done_q <= seq_done_d;
    end
  end

  assign sw_out   = sw_out_q;
  assign mode     = state_q;
  assign step_idx = step_q;
  assign seq_done = seq_done_q;

endmodule

// File: tb/tb_fsm_sw_sequencer.sv
// Testbench for fsm_sw_sequencer (TICK_DIV=4, DEB_CYC=3, SEQ_LEN=12).
// A reference model checks all outputs every cycle. The model treats the
// pattern position as a count of cycles spent in AUTO, and it debounces over a
// sliding window of synchronised samples.
`timescale 1ns/1ps
module tb_fsm_sw_sequencer;

  localparam int TD = 4;
  localparam int DC = 3;
  localparam int SL = 12;
`ifdef SEQ_DEBOUNCE_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] sw_in = 3'b000;
  logic       btn_mode = 1'b0;
  logic       btn_hold = 1'b0;
  logic [2:0] sw_out;
  logic [1:0] mode;
  logic [3:0] step_idx;
  logic       seq_done;

  fsm_sw_sequencer #(.TICK_DIV(TD), .DEB_CYC(DC), .SEQ_LEN(SL)) dut (
    .clk      (clk),
    .reset    (reset),
    .sw_in    (sw_in),
    .btn_mode (btn_mode),
    .btn_hold (btn_hold),
    .sw_out   (sw_out),
    .mode     (mode),
    .step_idx (step_idx),
    .seq_done (seq_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [2:0] pattern [SL] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
                               3'd6, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  int         m_mode;      // 0 manual, 1 auto, 2 pause
  int         m_pos;       // cycles spent advancing in AUTO since entry
  logic [2:0] m_sw;
  logic [2:0] m_filt;
  logic       m_done;
  logic [2:0] sw_hist[$];  // [0] = raw value at the previous edge, [1] = two edges ago, ...
  logic       mb_hist[$];
  logic       hb_hist[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pos  = 0;
    m_sw   = 3'b000;
    m_filt = 3'b000;
    m_done = 1'b0;
    sw_hist.delete();
    mb_hist.delete();
    hb_hist.delete();
    for (int i = 0; i < DC + 2; i++) begin
      sw_hist.push_back(3'b000);
      mb_hist.push_back(1'b0);
      hb_hist.push_back(1'b0);
    end
  endtask

  // Advance the model by one rising edge. The raw inputs passed in are the
  // values sampled at that edge.
  task automatic model_edge(input logic [2:0] s_raw, input logic bm, input logic bh);
    logic [2:0] s_sync;
    logic       me;
    logic       he;
    logic       stable;
    int         old_mode;
    s_sync = sw_hist[1];
    me     = mb_hist[1] & ~mb_hist[2];
    he     = hb_hist[1] & ~hb_hist[2];
`ifdef SEQ_DEBOUNCE_EN
    stable = 1'b1;
    for (int k = 1; k <= DC; k++)
      if (sw_hist[k] !== s_sync) stable = 1'b0;
    if (stable && s_sync !== m_filt) m_filt = s_sync;
`else
    stable = 1'b1;
    m_filt = s_sync;
`endif
    old_mode = m_mode;
    if (old_mode == 0) m_sw = m_filt;
    else if (old_mode == 1) m_sw = pattern[(m_pos / TD) % SL];
    m_done = 1'b0;
    if (me) begin
      m_mode = (old_mode == 0) ? 1 : 0;
      m_pos  = 0;
    end else if (he) begin
      if (old_mode == 1) m_mode = 2;
      else if (old_mode == 2) m_mode = 1;
    end else if (old_mode == 1) begin
      m_pos++;
      m_done = ((m_pos % (TD * SL)) == 0);
    end
    sw_hist.push_front(s_raw);
    void'(sw_hist.pop_back());
    mb_hist.push_front(bm);
    void'(mb_hist.pop_back());
    hb_hist.push_front(bh);
    void'(hb_hist.pop_back());
  endtask

  task automatic compare_all();
    int exp_step;
    exp_step = (m_mode == 0) ? 0 : (m_pos / TD) % SL;
    check("sw_out",   32'(sw_out),   32'(m_sw));
    check("mode",     32'(mode),     32'(m_mode));
    check("step_idx", 32'(step_idx), 32'(exp_step));
    check("seq_done", 32'(seq_done), 32'(m_done));
  endtask

  // Apply inputs at the falling edge, clock once, then compare at the next falling edge.
  task automatic cycle(input logic [2:0] s, input logic bm, input logic bh);
    sw_in    = s;
    btn_mode = bm;
    btn_hold = bh;
    @(posedge clk);
    model_edge(s, bm, bh);
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n, input logic [2:0] s);
    for (int i = 0; i < n; i++) cycle(s, 1'b0, 1'b0);
  endtask

  initial begin
    int       done_cnt;
    int       toggles;
    logic [1:0] prev_mode;
    logic       found;
    logic [2:0] rs;

    // 1. Reset held low for 20 ns
    model_reset();
    #20;
    check("rst_sw_out",   32'(sw_out),   32'd0);
    check("rst_mode",     32'(mode),     32'd0);
    check("rst_step",     32'(step_idx), 32'd0);
    check("rst_seq_done", 32'(seq_done), 32'd0);
    reset = 1'b1;
    run(3, 3'b000);

    // 2. Manual path latency
    for (int k = 1; k <= 8; k++) begin
      cycle(3'b101, 1'b0, 1'b0);
      check("man_latency", 32'(sw_out), (k >= LAT) ? 32'd5 : 32'd0);
    end
    run(8, 3'b000);
`ifdef SEQ_DEBOUNCE_EN
    run(2, 3'b101);
    for (int k = 0; k < 8; k++) begin
      cycle(3'b000, 1'b0, 1'b0);
      check("deb_glitch", 32'(sw_out), 32'd0);
    end
`endif

    // 3. Enter AUTO and run through one full wrap of the pattern
    cycle(3'b000, 1'b1, 1'b0);
    run(2, 3'b000);
    check("auto_entry", 32'(mode), 32'd1);
    done_cnt = 0;
    for (int k = 0; k < 52; k++) begin
      cycle(3'b000, 1'b0, 1'b0);
      if (seq_done) done_cnt++;
    end
    check("wrap_pulse_count", 32'(done_cnt), 32'd1);

    // 4. Pause at step 5, then resume
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      cycle(3'b010, 1'b0, 1'b0);
      if (step_idx == 4'd5) found = 1'b1;
    end
    check("wait_step5", 32'(found), 32'd1);
    cycle(3'b010, 1'b0, 1'b1);
    run(2, 3'b010);
    check("pause_mode", 32'(mode), 32'd2);
    for (int k = 0; k < 20; k++) begin
      cycle(3'b011, 1'b0, 1'b0);
      check("pause_frozen", 32'(sw_out), 32'd5);
    end
    cycle(3'b011, 1'b0, 1'b1);
    run(2, 3'b011);
    check("resume_mode", 32'(mode), 32'd1);
    run(8, 3'b011);

    // 5. Simultaneous buttons: the mode button wins. Then hold alone in MANUAL.
    cycle(3'b001, 1'b1, 1'b1);
    run(2, 3'b001);
    check("both_mode", 32'(mode), 32'd0);
    check("both_step", 32'(step_idx), 32'd0);
    cycle(3'b001, 1'b0, 1'b1);
    run(5, 3'b001);
    check("hold_in_manual", 32'(mode), 32'd0);

    // 6. Long button press toggles only once
    toggles   = 0;
    prev_mode = mode;
    for (int k = 0; k < 16; k++) begin
      cycle(3'b110, (k < 10) ? 1'b1 : 1'b0, 1'b0);
      if (mode !== prev_mode) toggles++;
      prev_mode = mode;
    end
    check("long_press_toggles", 32'(toggles), 32'd1);
    check("long_press_mode", 32'(mode), 32'd1);

    // Reset asserted mid-AUTO, checked before any clock edge
    run(10, 3'b110);
    check("pre_reset_auto", 32'(mode), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_sw_out",   32'(sw_out),   32'd0);
    check("mid_rst_mode",     32'(mode),     32'd0);
    check("mid_rst_step",     32'(step_idx), 32'd0);
    check("mid_rst_seq_done", 32'(seq_done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    reset = 1'b1;
    run(3, 3'b000);

    // Randomised stimulus against the model
    rs = 3'b000;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(5) == 0) rs = 3'($urandom_range(7));
      cycle(rs, ($urandom_range(59) == 0), ($urandom_range(14) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
